// File: rtl/fcc_pkg.sv
// Shared encodings for the label scheduler: FSM states, neighbor indices, union-find request kinds.
package fcc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MAKE  = 3'd1,
    ST_READ  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_UNION = 3'd4
  } fcc_state_t;

  localparam logic [1:0] NBR_W  = 2'd0;
  localparam logic [1:0] NBR_NW = 2'd1;
  localparam logic [1:0] NBR_N  = 2'd2;
  localparam logic [1:0] NBR_NE = 2'd3;

  localparam logic UN_MAKE  = 1'b0;
  localparam logic UN_UNION = 1'b1;

endpackage

// File: rtl/fcc_nbr_gen.sv
// Combinational neighbor generator: coordinates of neighbor k of (r,c) and whether it lies in the image.
module fcc_nbr_gen
  import fcc_pkg::*;
#(
  parameter int COLS  = 30,
  parameter int COL_W = 5
) (
  input  logic [7:0]       r,
  input  logic [COL_W-1:0] c,
  input  logic [1:0]       k,
  output logic [7:0]       nbr_row,
  output logic [COL_W-1:0] nbr_col,
  output logic             in_bounds
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  always_comb begin
    nbr_row   = r;
    nbr_col   = c;
    in_bounds = 1'b0;
    case (k)
      NBR_W: begin
        nbr_col   = c - 1'b1;
        in_bounds = (c != '0);
      end
      NBR_NW: begin
        nbr_row   = r - 1'b1;
        nbr_col   = c - 1'b1;
        in_bounds = (c != '0) && (r != '0);
      end
      NBR_N: begin
        nbr_row   = r - 1'b1;
        in_bounds = (r != '0);
      end
      default: begin
        nbr_row   = r - 1'b1;
        nbr_col   = c + 1'b1;
        in_bounds = (r != '0) && (c != COL_LAST);
      end
    endcase
  end

endmodule

// File: rtl/fcc_label_sched.sv
// Connected-component label scheduler: per accepted point, issue make-set, then probe the
// four causal neighbors and issue a union for every neighbor reported as a hit.
module fcc_label_sched
  import fcc_pkg::*;
#(
  parameter int ROWS  = 30,
  parameter int COLS  = 30,
  parameter int COL_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pt_valid,
  output logic             pt_ready,
  input  logic [7:0]       pt_row,
  input  logic [COL_W-1:0] pt_col,
  input  logic             pt_is_ground,
  output logic             rd_en,
  output logic [7:0]       rd_row,
  output logic [COL_W-1:0] rd_col,
  input  logic             rd_hit,
  output logic             un_valid,
  input  logic             un_ready,
  output logic             un_kind,
  output logic [7:0]       un_a_row,
  output logic [COL_W-1:0] un_a_col,
  output logic [7:0]       un_b_row,
  output logic [COL_W-1:0] un_b_col,
  output logic             busy,
  output logic             frame_done,
  output logic             err_coord,
  output logic [CNT_W-1:0] union_cnt
);

  // state | meaning
  // IDLE  | waiting for a point (pt_ready=1)
  // MAKE  | make-set request outstanding
  // READ  | neighbor read issued
  // WAIT  | rd_hit sampled
  // UNION | union request outstanding

  localparam logic [7:0]       ROW_LAST = 8'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  fcc_state_t       state, state_nxt;
  logic [7:0]       cur_row;
  logic [COL_W-1:0] cur_col;
  logic [1:0]       k_q, k_nxt;

  logic [7:0]       n_row [4];
  logic [COL_W-1:0] n_col [4];
  logic [3:0]       n_inb;

  for (genvar g = 0; g < 4; g++) begin : g_nbr
    fcc_nbr_gen #(.COLS(COLS), .COL_W(COL_W)) u_nbr (
      .r        (cur_row),
      .c        (cur_col),
      .k        (2'(g)),
      .nbr_row  (n_row[g]),
      .nbr_col  (n_col[g]),
      .in_bounds(n_inb[g])
    );
  end

  // Next in-bounds neighbor at or after scan_from; out-of-bounds ones are skipped in zero cycles.
  logic [2:0] scan_from;
  logic       scan_hit;
  logic [1:0] scan_k;

  always_comb begin
    scan_from = (state == ST_MAKE) ? 3'd0 : ({1'b0, k_q} + 3'd1);
    scan_hit  = 1'b0;
    scan_k    = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (n_inb[i] && (i >= int'(scan_from))) begin
        scan_hit = 1'b1;
        scan_k   = 2'(i);
      end
    end
  end

  logic pt_oor, pt_last, cur_last;
  logic capture, set_err, cnt_inc, done_evt, advance;

  assign pt_oor   = (pt_row > ROW_LAST) || (pt_col > COL_LAST);
  assign pt_last  = (pt_row == ROW_LAST) && (pt_col == COL_LAST);
  assign cur_last = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

  always_comb begin
    state_nxt = state;
    k_nxt     = k_q;
    capture   = 1'b0;
    set_err   = 1'b0;
    cnt_inc   = 1'b0;
    done_evt  = 1'b0;
    advance   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pt_valid) begin
          if (pt_oor) begin
            set_err = 1'b1;
          end else if (pt_is_ground) begin
            done_evt = pt_last;
          end else begin
            capture   = 1'b1;
            state_nxt = ST_MAKE;
          end
        end
      end
      ST_MAKE:  advance   = un_ready;
      ST_READ:  state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (rd_hit) state_nxt = ST_UNION;
        else        advance   = 1'b1;
      end
      ST_UNION: begin
        cnt_inc = un_ready;
        advance = un_ready;
      end
      default:  state_nxt = ST_IDLE;
    endcase
    if (advance) begin
      if (scan_hit) begin
        state_nxt = ST_READ;
        k_nxt     = scan_k;
      end else begin
        state_nxt = ST_IDLE;
        done_evt  = cur_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cur_row    <= '0;
      cur_col    <= '0;
      k_q        <= '0;
      err_coord  <= 1'b0;
      union_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      k_q        <= k_nxt;
      frame_done <= done_evt;
      if (capture) begin
        cur_row <= pt_row;
        cur_col <= pt_col;
      end
      if (set_err) err_coord <= 1'b1;
      if (cnt_inc && (union_cnt != '1)) union_cnt <= union_cnt + 1'b1;
    end
  end

  assign pt_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign rd_en    = (state == ST_READ);
  assign un_valid = (state == ST_MAKE) || (state == ST_UNION);
  assign un_kind  = (state == ST_UNION) ? UN_UNION : UN_MAKE;
  assign rd_row   = rd_en ? n_row[k_q] : '0;
  assign rd_col   = rd_en ? n_col[k_q] : '0;
  assign un_a_row = un_valid ? cur_row : '0;
  assign un_a_col = un_valid ? cur_col : '0;
  assign un_b_row = (state == ST_UNION) ? n_row[k_q] : '0;
  assign un_b_col = (state == ST_UNION) ? n_col[k_q] : '0;

endmodule

// File: tb/tb_fcc_label_sched.sv
// Self-checking bench for fcc_label_sched: directed corner points plus random points against a
// neighbor-list reference model.
module tb_fcc_label_sched;
  localparam int ROWS = 30, COLS = 30, COL_W = 5, CNT_W = 16;
  localparam int BUDGET = 100;

  logic clk = 1'b0;
  logic rst, pt_valid, pt_ready, pt_is_ground, rd_en, rd_hit;
  logic un_valid, un_ready, un_kind, busy, frame_done, err_coord;
  logic [7:0] pt_row, rd_row, un_a_row, un_b_row;
  logic [COL_W-1:0] pt_col, rd_col, un_a_col, un_b_col;
  logic [CNT_W-1:0] union_cnt;

  fcc_label_sched #(.ROWS(ROWS), .COLS(COLS), .COL_W(COL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_row(pt_row), .pt_col(pt_col), .pt_is_ground(pt_is_ground),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_hit(rd_hit),
    .un_valid(un_valid), .un_ready(un_ready), .un_kind(un_kind),
    .un_a_row(un_a_row), .un_a_col(un_a_col), .un_b_row(un_b_row), .un_b_col(un_b_col),
    .busy(busy), .frame_done(frame_done), .err_coord(err_coord), .union_cnt(union_cnt)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cnt_exp = 0;
  bit err_exp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_pt_ready"}, pt_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_un_valid"}, un_valid, 0);
    chk({tag, "_un_kind"}, un_kind, 0);
    chk({tag, "_rd_coord"}, {19'd0, rd_row, rd_col}, 0);
    chk({tag, "_un_coord"}, {6'd0, un_a_row, un_a_col, un_b_row, un_b_col}, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_err_coord"}, err_coord, 0);
    chk({tag, "_union_cnt"}, union_cnt, 0);
  endtask

  // mode 0: un_ready always 1; mode 1: random un_ready; mode 2: each union stalled 3 cycles
  task automatic run_point(input int r, input int c, input bit g, input bit [3:0] hm, input int mode);
    int dr[4] = '{0, -1, -1, -1};
    int dc[4] = '{-1, -1, 0, 1};
    int nr[$], nc[$], eur[$], euc[$], ur[$], uc[$];
    int nreads, nmake, uv_cyc, fd, make_cyc, stall, nh, cycles, exp_fd;
    bit oor, active, pend, held, busy1;
    logic [31:0] hw, cw;

    oor = (r >= ROWS) || (c >= COLS);
    active = !oor && !g;
    nh = 0;
    if (active) begin
      for (int i = 0; i < 4; i++) begin
        if ((r + dr[i] >= 0) && (c + dc[i] >= 0) && (c + dc[i] < COLS)) begin
          if (hm[nr.size()]) begin
            eur.push_back(r + dr[i]);
            euc.push_back(c + dc[i]);
            nh++;
          end
          nr.push_back(r + dr[i]);
          nc.push_back(c + dc[i]);
        end
      end
    end
    exp_fd = (!oor && r == ROWS - 1 && c == COLS - 1) ? 1 : 0;

    nreads = 0; nmake = 0; uv_cyc = 0; fd = 0; make_cyc = -1; stall = 0;
    pend = 0; held = 0; hw = '0; busy1 = 0;

    @(negedge clk);
    chk("pt_ready_before", pt_ready, 1);
    pt_valid = 1'b1; pt_row = 8'(r); pt_col = COL_W'(c); pt_is_ground = g;
    @(posedge clk);
    @(negedge clk);
    pt_valid = 1'b0;
    for (cycles = 1; cycles <= BUDGET; cycles++) begin
      if (cycles > 1) @(negedge clk);
      if (cycles == 1) busy1 = busy;
      fd += int'(frame_done);
      rd_hit = pend;
      pend = 0;
      if (rd_en) begin
        if (nreads < nr.size()) begin
          chk("rd_row", rd_row, nr[nreads]);
          chk("rd_col", rd_col, nc[nreads]);
          pend = hm[nreads];
        end
        nreads++;
      end
      cw = {5'd0, un_kind, un_a_row, un_a_col, un_b_row, un_b_col};
      if (held) begin
        chk("un_hold_valid", un_valid, 1);
        chk("un_hold_fields", cw, hw);
      end
      if (un_valid && un_kind) uv_cyc++;
      if (mode == 0) un_ready = 1'b1;
      else if (mode == 1) un_ready = 1'($urandom_range(0, 1));
      else if (un_valid && un_kind && stall < 3) begin
        un_ready = 1'b0;
        stall++;
      end else un_ready = 1'b1;
      if (un_valid) begin
        if (un_ready) begin
          held = 0;
          stall = 0;
          chk("un_a", {19'd0, un_a_row, un_a_col}, {19'd0, 8'(r), COL_W'(c)});
          if (!un_kind) begin
            nmake++;
            if (make_cyc < 0) make_cyc = cycles;
            chk("make_b_zero", {19'd0, un_b_row, un_b_col}, 0);
          end else begin
            ur.push_back(int'(un_b_row));
            uc.push_back(int'(un_b_col));
          end
        end else begin
          held = 1;
          hw = cw;
        end
      end
      if (pt_ready) break;
    end
    chk("point_done", pt_ready, 1);
    chk("busy_done", busy, 0);
    chk("busy_first", busy1, active);
    @(negedge clk);
    fd += int'(frame_done);
    rd_hit = 1'b0;
    un_ready = 1'b0;

    if (active) cnt_exp += nh;
    if (oor) err_exp = 1'b1;
    chk("n_reads", nreads, nr.size());
    chk("n_make", nmake, active);
    chk("n_union", ur.size(), eur.size());
    for (int j = 0; j < eur.size() && j < ur.size(); j++) begin
      chk("union_b_row", ur[j], eur[j]);
      chk("union_b_col", uc[j], euc[j]);
    end
    chk("frame_done_cnt", fd, exp_fd);
    chk("err_coord", err_coord, err_exp);
    chk("union_cnt", union_cnt, cnt_exp);
    if (mode == 0) begin
      chk("latency", cycles, active ? (2 + 2 * nr.size() + nh) : 1);
      if (active) chk("make_cycle", make_cyc, 1);
      chk("union_valid_cycles", uv_cyc, nh);
    end
    if (mode == 2) chk("union_hold_cycles", uv_cyc, 4 * nh);
  endtask

  initial begin
    bit found;
    rst = 1'b1; pt_valid = 1'b0; pt_row = '0; pt_col = '0; pt_is_ground = 1'b0;
    rd_hit = 1'b0; un_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    run_point(5, 7, 1'b0, 4'b0000, 0);
    run_point(0, 0, 1'b0, 4'b1111, 0);
    run_point(3, 29, 1'b0, 4'b0000, 0);
    run_point(5, 7, 1'b0, 4'b0100, 2);
    run_point(29, 29, 1'b1, 4'b0000, 0);
    run_point(30, 0, 1'b0, 4'b0000, 0);
    run_point(29, 29, 1'b0, 4'b0111, 1);
    run_point(0, 12, 1'b0, 4'b1111, 0);
    run_point(14, 0, 1'b0, 4'b0011, 2);

    for (int n = 0; n < 40; n++) begin
      run_point($urandom_range(0, 31), $urandom_range(0, 31), ($urandom_range(0, 3) == 0),
                4'($urandom_range(0, 15)), 1);
    end

    // reset while a union is stalled
    @(negedge clk);
    pt_valid = 1'b1; pt_row = 8'd5; pt_col = COL_W'(7); pt_is_ground = 1'b0;
    @(posedge clk);
    @(negedge clk);
    pt_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      rd_hit = 1'b1;
      if (un_valid && un_kind) begin
        found = 1'b1;
        break;
      end
      un_ready = 1'b1;
    end
    un_ready = 1'b0;
    rst = 1'b1;
    chk("reach_union", found, 1);
    chk("cnt_before_rst", (union_cnt != 0), 1);
    @(posedge clk);
    @(negedge clk);
    rd_hit = 1'b0;
    check_idle_outputs("rst_union");
    rst = 1'b0;
    cnt_exp = 0;
    err_exp = 1'b0;
    run_point(5, 7, 1'b0, 4'b1001, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
